seq_divider_16bit: RTL and testbench

Multi-cycle 16-bit integer divider built from one shared shift/subtract datapath, one quotient bit per clock. It runs the subtract path of the datapath iteratively and reports quotient, remainder and exception flags. Signed or unsigned mode is selected per operation. It sits beside the combinational 16-bit add/sub unit in the datapath and reports divide-by-zero and signed overflow through the same style of one-bit flags.

---
 rtl/seq_divider_16bit_if.sv | 26 ++
 rtl/seq_divider_16bit.sv | 160 ++++++++++++++++
 tb/tb_seq_divider_16bit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_16bit_if.sv
// Request/result bundle of the sequential divider: operands and mode in, quotient/remainder/flags out.
// start is only honoured while busy is low; results hold until the next done pulse.
interface seq_divider_16bit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sign_ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             DZ;
  logic             O;

  modport master (
    output start, A, B, Sign_ctrl,
    input  busy, done, Q, R, DZ, O
  );

  modport slave (
    input  start, A, B, Sign_ctrl,
    output busy, done, Q, R, DZ, O
  );
endinterface

// File: rtl/seq_divider_16bit.sv
// Restoring shift/subtract divider, one quotient bit per clock; done 17 edges after start (1 for divide-by-zero).
// No queueing: start is ignored while busy, results and flags hold until the next done pulse.
module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_divider_16bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;
    logic             ovf;
  } res_t;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_sel_q, dz_sel_d;
  logic             ovf_sel_q, ovf_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  res_t             res_q, res_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  assign a_neg  = bus.Sign_ctrl & bus.A[WIDTH-1];
  assign b_neg  = bus.Sign_ctrl & bus.B[WIDTH-1];
  assign a_mag  = a_neg ? -bus.A : bus.A;
  assign b_mag  = b_neg ? -bus.B : bus.B;
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_sel_d  = dz_sel_q;
    ovf_sel_d = ovf_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    res_d     = res_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d    = 1'b1;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          rem_d     = '0;
          cnt_d     = '0;
          dvs_d     = b_mag;
          ovf_sel_d = bus.Sign_ctrl && (bus.A == MIN_NEG) && (bus.B == ALL_ONES);
          // Divide-by-zero keeps the raw dividend so it can be returned as the remainder.
          if (bus.B == '0) begin
            dz_sel_d = 1'b1;
            dvd_d    = bus.A;
            state_d  = S_FIX;
          end else begin
            dz_sel_d = 1'b0;
            dvd_d    = a_mag;
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        // The dividend register shifts left and collects quotient bits in its LSB.
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (dz_sel_q) begin
          res_d.quo = ALL_ONES;
          res_d.rem = dvd_q;
          res_d.dz  = 1'b1;
          res_d.ovf = 1'b0;
        end else begin
          // MIN/-1 wraps naturally to MIN here; only the flag needs extra state.
          res_d.quo = neg_quo_q ? -dvd_q : dvd_q;
          res_d.rem = neg_rem_q ? -rem_q : rem_q;
          res_d.dz  = 1'b0;
          res_d.ovf = ovf_sel_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_sel_q  <= 1'b0;
      ovf_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_sel_q  <= dz_sel_d;
      ovf_sel_q <= ovf_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      res_q     <= res_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Q    = res_q.quo;
  assign bus.R    = res_q.rem;
  assign bus.DZ   = res_q.dz;
  assign bus.O    = res_q.ovf;
endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed bench for seq_divider_16bit: expected results are queued at issue and compared at done.
module tb_seq_divider_16bit;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_divider_16bit_if #(.WIDTH(16)) bus ();

  seq_divider_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   k_start  = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] q, input logic [15:0] r,
                      input logic dz, input logic o);
    exp_t e;
    e.tag = tag; e.q = q; e.r = r; e.dz = dz; e.o = o;
    sb.push_back(e);
  endtask

  // Start is sampled at the next rising edge; operands are scrambled right after.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus.start     = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.Sign_ctrl = s;
    @(posedge clk);
    #1;
    k_start       = cyc;
    bus.start     = 1'b0;
    bus.A         = 16'($urandom);
    bus.B         = 16'($urandom);
    bus.Sign_ctrl = 1'($urandom);
  endtask

  task automatic wait_result(input int exp_lat, output int busy_n);
    bit   got;
    exp_t e;
    got    = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got = 1'b1;
      else if (bus.busy === 1'b1) busy_n++;
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".lat"},  32'(cyc - k_start), 32'(exp_lat));
        check({e.tag, ".Q"},    32'(bus.Q),    32'(e.q));
        check({e.tag, ".R"},    32'(bus.R),    32'(e.r));
        check({e.tag, ".DZ"},   32'(bus.DZ),   32'(e.dz));
        check({e.tag, ".O"},    32'(bus.O),    32'(e.o));
        check({e.tag, ".busy"}, 32'(bus.busy), 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bn;
    int d0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Sign_ctrl = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.Q",    32'(bus.Q),    32'd0);
    check("rst.R",    32'(bus.R),    32'd0);
    check("rst.DZ",   32'(bus.DZ),   32'd0);
    check("rst.O",    32'(bus.O),    32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push("u100_7", 16'd14, 16'd2, 1'b0, 1'b0);
    issue(16'd100, 16'd7, 1'b0);
    wait_result(17, bn);
    check("u100_7.busy_cycles", 32'(bn), 32'd17);
    repeat (2) @(negedge clk);

    push("s_m7_2", 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    issue(16'hFFF9, 16'd2, 1'b1);
    wait_result(17, bn);
    repeat (2) @(negedge clk);

    push("s_7_m2", 16'hFFFD, 16'h0001, 1'b0, 1'b0);
    issue(16'd7, 16'hFFFE, 1'b1);
    wait_result(17, bn);
    repeat (2) @(negedge clk);

    push("s_m100_m7", 16'h000E, 16'hFFFE, 1'b0, 1'b0);
    issue(16'hFF9C, 16'hFFF9, 1'b1);
    wait_result(17, bn);
    repeat (2) @(negedge clk);

    push("dz_1234", 16'hFFFF, 16'h1234, 1'b1, 1'b0);
    issue(16'h1234, 16'h0000, 1'b0);
    wait_result(1, bn);
    check("dz_1234.busy_cycles", 32'(bn), 32'd1);
    push("u10_3", 16'd3, 16'd1, 1'b0, 1'b0);
    issue(16'd10, 16'd3, 1'b0);
    wait_result(17, bn);
    repeat (2) @(negedge clk);

    push("dz_s8000", 16'hFFFF, 16'h8000, 1'b1, 1'b0);
    issue(16'h8000, 16'h0000, 1'b1);
    wait_result(1, bn);
    push("dz_00ff", 16'hFFFF, 16'h00FF, 1'b1, 1'b0);
    issue(16'h00FF, 16'h0000, 1'b0);
    wait_result(1, bn);
    repeat (2) @(negedge clk);

    push("ovf_s", 16'h8000, 16'h0000, 1'b0, 1'b1);
    issue(16'h8000, 16'hFFFF, 1'b1);
    wait_result(17, bn);
    repeat (2) @(negedge clk);
    push("ovf_u", 16'h0000, 16'h8000, 1'b0, 1'b0);
    issue(16'h8000, 16'hFFFF, 1'b0);
    wait_result(17, bn);
    repeat (2) @(negedge clk);
    push("u8000_1", 16'h8000, 16'h0000, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0);
    wait_result(17, bn);
    repeat (5) @(negedge clk);
    check("hold.Q",    32'(bus.Q),    32'h8000);
    check("hold.R",    32'(bus.R),    32'h0000);
    check("hold.done", 32'(bus.done), 32'd0);

    push("u1000_7", 16'd142, 16'd6, 1'b0, 1'b0);
    issue(16'd1000, 16'd7, 1'b0);
    repeat (5) @(negedge clk);
    bus.start     = 1'b1;
    bus.A         = 16'd5;
    bus.B         = 16'd1;
    bus.Sign_ctrl = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_result(17, bn);
    push("b2b_c350_12c", 16'h00A6, 16'h00C8, 1'b0, 1'b0);
    issue(16'hC350, 16'h012C, 1'b0);
    wait_result(17, bn);
    repeat (2) @(negedge clk);

    issue(16'd1000, 16'd3, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.done", 32'(bus.done), 32'd0);
    check("midrst.Q",    32'(bus.Q),    32'd0);
    check("midrst.R",    32'(bus.R),    32'd0);
    check("midrst.DZ",   32'(bus.DZ),   32'd0);
    check("midrst.O",    32'(bus.O),    32'd0);
    d0 = done_cnt;
    repeat (25) @(negedge clk);
    check("midrst.no_done", 32'(done_cnt), 32'(d0));

    push("u_ffff_10", 16'h0FFF, 16'h000F, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0010, 1'b0);
    wait_result(17, bn);
    repeat (2) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
